// File: rtl/issue_queue_pkg.sv
// Shared core types for the decode -> dispatch path.
// decode_result is the record carried through the issue queue.
package issue_queue_pkg;

  typedef enum logic [2:0] {
    UNIT_ALU,
    UNIT_MUL,
    UNIT_DIV,
    UNIT_LSU,
    UNIT_BRU
  } unit;

  typedef enum logic [1:0] {
    LDST_NONE,
    LDST_LOAD,
    LDST_STORE
  } ldst_mode;

  typedef struct packed {
    logic        is_valid;
    logic [31:0] pc;
    unit         fu;
    ldst_mode    mode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } decode_result;

endpackage

// File: rtl/issue_queue_if.sv
// Decode/dispatch-facing signal bundle of the issue queue.
// master = decode + dispatch side, slave = the queue itself.
interface issue_queue_if
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  decode_result    in_entry  [2];
  logic            in_ready;
  decode_result    out_entry [2];
  logic [1:0]      out_valid;
  logic [1:0]      accept;
  logic [CW-1:0]   count;

  modport master (
    output in_entry, accept,
    input  in_ready, out_entry, out_valid, count
  );

  modport slave (
    input  in_entry, accept,
    output in_ready, out_entry, out_valid, count
  );

endinterface

// File: rtl/issue_queue.sv
// In-order dual-issue buffer between decode and reservation-station dispatch.
// Accepts up to two entries and releases up to two oldest entries per cycle.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input logic          clk,
  input logic          rst,
  input logic          flush,
  issue_queue_if.slave q
);

  localparam int PW = $clog2(DEPTH);

  decode_result  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          v0;
  logic          v1;
  logic          a0;
  logic          a1;
  logic [1:0]    n_in;
  logic [1:0]    n_out;
  logic [PW-1:0] wr1_idx;
  logic          ready;
  logic [1:0]    valid;

  // Readiness depends on registered occupancy only, so a same-cycle
  // dequeue can never open the door for an incoming pair.
  always_comb begin
    ready    = (count <= CW'(DEPTH - 2));
    valid[0] = (count != '0);
    valid[1] = (count >= CW'(2));
  end

  always_comb begin
    v0      = q.in_entry[0].is_valid;
    v1      = q.in_entry[1].is_valid;
    n_in    = ready ? (2'(v0) + 2'(v1)) : 2'd0;
    // A lone valid slot 1 is compacted down to the tail slot.
    wr1_idx = tail + PW'(v0);
    a0      = q.accept[0] & valid[0];
    a1      = q.accept[1] & valid[1];
    n_out   = 2'(a0) + 2'(a0 & a1);
  end

  always_comb begin
    q.in_ready              = ready;
    q.out_valid             = valid;
    q.count                 = count;
    q.out_entry[0]          = mem[head];
    q.out_entry[0].is_valid = valid[0];
    q.out_entry[1]          = mem[head + PW'(1)];
    q.out_entry[1].is_valid = valid[1];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(n_out);
      tail  <= tail + PW'(n_in);
      count <= count + CW'(n_in) - CW'(n_out);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && ready) begin
      if (v0) mem[tail]    <= q.in_entry[0];
      if (v1) mem[wr1_idx] <= q.in_entry[1];
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed vectors, corner sequences
// and a randomized run against a queue-based reference model.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  issue_queue_if #(.DEPTH(DEPTH)) iq ();

  issue_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .q     (iq)
  );

  int tests  = 0;
  int failed = 0;

  decode_result mq [$];

  typedef struct {
    logic        r;
    logic        f;
    logic [1:0]  vin;      // bit i = in_entry[i].is_valid
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic [1:0]  acc;      // bit i = accept[i]
    int          exp_count;
    logic        exp_ready;
    logic [1:0]  exp_valid; // bit i = out_valid[i]
    logic [31:0] exp_pc0;
    logic [31:0] exp_pc1;
  } vec_t;

  vec_t vecs [10];

  function automatic decode_result mk(input logic [31:0] pc, input logic v);
    decode_result e;
    e          = '0;
    e.is_valid = v;
    e.pc       = pc;
    e.fu       = UNIT_LSU;
    e.mode     = pc[2] ? LDST_LOAD : LDST_STORE;
    e.rd       = pc[6:2];
    e.rs1      = pc[7:3];
    e.rs2      = pc[8:4];
    e.imm      = ~pc;
    return e;
  endfunction

  function automatic decode_result rnd_entry(input logic v);
    decode_result e;
    e          = '0;
    e.is_valid = v;
    e.pc       = $urandom;
    e.fu       = unit'($urandom_range(0, 4));
    e.mode     = ldst_mode'($urandom_range(0, 2));
    e.rd       = 5'($urandom);
    e.rs1      = 5'($urandom);
    e.rs2      = 5'($urandom);
    e.imm      = $urandom;
    return e;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic [1:0] vin,
                       input logic [31:0] p0, input logic [31:0] p1, input logic [1:0] acc);
    rst            = r;
    flush          = f;
    iq.in_entry[0] = mk(p0, vin[0]);
    iq.in_entry[1] = mk(p1, vin[1]);
    iq.accept      = acc;
  endtask

  // Reference: a FIFO of entries; pops from the front, pushes to the back.
  task automatic model_step();
    int sz;
    int nout;
    if (rst || flush) begin
      mq.delete();
    end else begin
      sz   = mq.size();
      nout = 0;
      if (iq.accept[0] && sz >= 1) nout = (iq.accept[1] && sz >= 2) ? 2 : 1;
      repeat (nout) void'(mq.pop_front());
      if (DEPTH - sz >= 2) begin
        if (iq.in_entry[0].is_valid) mq.push_back(iq.in_entry[0]);
        if (iq.in_entry[1].is_valid) mq.push_back(iq.in_entry[1]);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = mq.size();
    chk({tag, ".count"}, 128'(iq.count), 128'(sz));
    chk({tag, ".bound"}, 128'(iq.count <= DEPTH), 128'(1));
    chk({tag, ".in_ready"}, 128'(iq.in_ready), 128'(DEPTH - sz >= 2));
    chk({tag, ".out_valid"}, 128'(iq.out_valid), 128'({sz >= 2, sz >= 1}));
    if (sz >= 1) chk({tag, ".out0"}, 128'(iq.out_entry[0]), 128'(mq[0]));
    if (sz >= 2) chk({tag, ".out1"}, 128'(iq.out_entry[1]), 128'(mq[1]));
  endtask

  initial begin
    //         r     f     vin    pc0         pc1         acc    cnt rdy  valid  epc0        epc1
    vecs[0] = '{1'b1, 1'b0, 2'b00, 32'h0,     32'h0,     2'b00, 0, 1'b1, 2'b00, 32'h0,     32'h0};
    vecs[1] = '{1'b1, 1'b0, 2'b00, 32'h0,     32'h0,     2'b00, 0, 1'b1, 2'b00, 32'h0,     32'h0};
    vecs[2] = '{1'b0, 1'b0, 2'b11, 32'h100,   32'h104,   2'b00, 2, 1'b1, 2'b11, 32'h100,   32'h104};
    vecs[3] = '{1'b0, 1'b0, 2'b00, 32'h0,     32'h0,     2'b10, 2, 1'b1, 2'b11, 32'h100,   32'h104};
    vecs[4] = '{1'b0, 1'b0, 2'b00, 32'h0,     32'h0,     2'b11, 0, 1'b1, 2'b00, 32'h0,     32'h0};
    vecs[5] = '{1'b0, 1'b0, 2'b10, 32'h0,     32'h200,   2'b00, 1, 1'b1, 2'b01, 32'h200,   32'h0};
    vecs[6] = '{1'b0, 1'b0, 2'b00, 32'h0,     32'h0,     2'b01, 0, 1'b1, 2'b00, 32'h0,     32'h0};
    vecs[7] = '{1'b0, 1'b0, 2'b01, 32'h210,   32'h0,     2'b11, 1, 1'b1, 2'b01, 32'h210,   32'h0};
    vecs[8] = '{1'b0, 1'b0, 2'b11, 32'h220,   32'h224,   2'b01, 2, 1'b1, 2'b11, 32'h220,   32'h224};
    vecs[9] = '{1'b0, 1'b0, 2'b00, 32'h0,     32'h0,     2'b11, 0, 1'b1, 2'b00, 32'h0,     32'h0};

    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].r, vecs[i].f, vecs[i].vin, vecs[i].pc0, vecs[i].pc1, vecs[i].acc);
      cycle();
      chk($sformatf("vec%0d.count", i), 128'(iq.count), 128'(vecs[i].exp_count));
      chk($sformatf("vec%0d.in_ready", i), 128'(iq.in_ready), 128'(vecs[i].exp_ready));
      chk($sformatf("vec%0d.out_valid", i), 128'(iq.out_valid), 128'(vecs[i].exp_valid));
      if (vecs[i].exp_valid[0]) chk($sformatf("vec%0d.pc0", i), 128'(iq.out_entry[0].pc), 128'(vecs[i].exp_pc0));
      if (vecs[i].exp_valid[1]) chk($sformatf("vec%0d.pc1", i), 128'(iq.out_entry[1].pc), 128'(vecs[i].exp_pc1));
      check_model($sformatf("vec%0d", i));
    end

    // Fill to DEPTH-1, hold a pair while blocked, then release it.
    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 2'b11, 32'h400 + 32'(8 * k), 32'h404 + 32'(8 * k), 2'b00);
      cycle();
      check_model("fill");
    end
    drive(1'b0, 1'b0, 2'b01, 32'h418, 32'h0, 2'b00);
    cycle();
    chk("fill.count7", 128'(iq.count), 128'(7));
    chk("fill.blocked", 128'(iq.in_ready), 128'(0));
    drive(1'b0, 1'b0, 2'b11, 32'hA00, 32'hA04, 2'b00);
    cycle();
    chk("hold.count", 128'(iq.count), 128'(7));
    chk("hold.head", 128'(iq.out_entry[0].pc), 128'(32'h400));
    drive(1'b0, 1'b0, 2'b11, 32'hA00, 32'hA04, 2'b11);
    cycle();
    chk("release.count", 128'(iq.count), 128'(5));
    chk("release.ready", 128'(iq.in_ready), 128'(1));
    chk("release.head", 128'(iq.out_entry[0].pc), 128'(32'h408));
    drive(1'b0, 1'b0, 2'b11, 32'hA00, 32'hA04, 2'b00);
    cycle();
    chk("held_enq.count", 128'(iq.count), 128'(7));
    check_model("held_enq");
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b11);
      cycle();
      check_model("drain1");
    end

    // Wrap: reach head=6, tail=7, then write a pair across the boundary.
    drive(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 2'b00);
    cycle();
    chk("wflush.count", 128'(iq.count), 128'(0));
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 2'b11, 32'h500 + 32'(8 * k), 32'h504 + 32'(8 * k), 2'b00);
      cycle();
    end
    drive(1'b0, 1'b0, 2'b01, 32'h518, 32'h0, 2'b00);
    cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b11);
      cycle();
      check_model("wprep");
    end
    chk("wprep.count", 128'(iq.count), 128'(1));
    drive(1'b0, 1'b0, 2'b11, 32'h300, 32'h304, 2'b01);
    cycle();
    chk("wrap.count", 128'(iq.count), 128'(2));
    chk("wrap.pc0", 128'(iq.out_entry[0].pc), 128'(32'h300));
    chk("wrap.pc1", 128'(iq.out_entry[1].pc), 128'(32'h304));
    chk("wrap.mem7", 128'(dut.mem[7].pc), 128'(32'h300));
    chk("wrap.mem0", 128'(dut.mem[0].pc), 128'(32'h304));
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b01);
    cycle();
    chk("wrap.drain_pc", 128'(iq.out_entry[0].pc), 128'(32'h304));
    check_model("wrap_drain");
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b11);
    cycle();
    check_model("wrap_empty");

    // Flush with a concurrent enqueue and dequeue.
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 2'b11, 32'h600 + 32'(8 * k), 32'h604 + 32'(8 * k), 2'b00);
      cycle();
    end
    chk("preflush.count", 128'(iq.count), 128'(4));
    drive(1'b0, 1'b1, 2'b11, 32'h700, 32'h704, 2'b11);
    cycle();
    chk("flush.count", 128'(iq.count), 128'(0));
    chk("flush.out_valid", 128'(iq.out_valid), 128'(0));
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    cycle();
    chk("postflush.count", 128'(iq.count), 128'(0));
    drive(1'b0, 1'b0, 2'b01, 32'h710, 32'h0, 2'b00);
    cycle();
    chk("postflush.pc0", 128'(iq.out_entry[0].pc), 128'(32'h710));
    check_model("postflush");

    // Randomized traffic against the reference FIFO.
    for (int n = 0; n < 800; n++) begin
      rst            = ($urandom_range(0, 199) == 0);
      flush          = ($urandom_range(0, 39) == 0);
      iq.in_entry[0] = rnd_entry(1'($urandom));
      iq.in_entry[1] = rnd_entry(1'($urandom));
      iq.accept      = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom);
      cycle();
      check_model($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- In-order instruction buffer between the dual-decode stage and reservation-station dispatch.
- Each cycle it accepts up to two decode_result entries (slot 0 is older) and presents the two oldest buffered entries to dispatch.
- Dispatch consumes 0, 1 or 2 entries per cycle under a per-slot accept handshake.
- It asserts backpressure to fetch/decode when it cannot take a full pair, and is cleared by a flush on branch mispredict.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 4.
- CW, $clog2(DEPTH)+1, width of the occupancy counter (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active high.
- flush  in  1  discard all buffered entries.
- in_entry[2]  in  decode_result  decoded pair from decode; entry is_valid marks a real instruction.
- in_ready  out  1  queue accepts a pair this cycle.
- out_entry[2]  out  decode_result  two oldest entries; slot 0 is the head.
- out_valid[2]  out  1 each  out_entry[i] holds a real entry.
- accept[2]  in  1 each  dispatch takes out_entry[i] this cycle.
- count  out  CW  current occupancy.

Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.

Behaviour:
- Storage: circular buffer of DEPTH decode_result entries.
  - head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is a registered counter.
  - Storage array is not reset.
- Reset (rst=1 at posedge): head=0, tail=0, count=0. As a consequence, in_ready=1 and out_valid={0,0} from the following cycle.
- in_ready = (DEPTH - count >= 2). It is computed from registered count only; a same-cycle dequeue never raises it.
- Enqueue happens at posedge when in_ready=1.
  - n_in = in_entry[0].is_valid + in_entry[1].is_valid.
  - Valid entries are written in order, compacted: if only in_entry[1] is valid, it is written at tail.
  - tail advances by n_in.
  - When in_ready=0, inputs are ignored; decode must hold them.
- Output view (combinational from head and count):
  - out_valid[0] = (count>=1); out_valid[1] = (count>=2).
  - out_entry[i] = mem[head+i mod DEPTH].
  - The is_valid field of out_entry[i] is forced to out_valid[i].
  - Other fields are don't-care when out_valid[i]=0.
- Dequeue: n_out = a0 + (a0 & a1), where a0 = accept[0] & out_valid[0] and a1 = accept[1] & out_valid[1].
  - accept[1] without accept[0] is ignored (in-order only).
  - accept on an invalid slot is ignored.
  - head advances by n_out.
- Simultaneous enqueue and dequeue: count_next = count + n_in - n_out. Legal in every combination, including when count=DEPTH-2 or count=0.
  - No bypass: an entry enqueued in cycle t is first visible on out_* in cycle t+1.
  - Latency is 1 cycle minimum.
- Full: count=DEPTH-1 or DEPTH gives in_ready=0. Dequeue still operates.
- Empty: count=0 gives out_valid={0,0}. accept has no effect.
- Wrap-around: pointers wrap cleanly. A pair written at tail=DEPTH-1 occupies indices DEPTH-1 and 0.
- Flush (flush=1 at posedge): same effect as reset on head, tail and count. Same-cycle enqueue and dequeue are discarded.
- Priority: rst > flush > normal operation.
- Assertion (bench): count never exceeds DEPTH and never underflows.

Decomposition:
- decode_result, unit and ldst_mode typedefs belong in the shared core package and are imported here, not redefined.
- No sub-module; pointer and count logic stay inline.

Test Plan:
- Reset then idle: rst for 2 cycles -> count=0, in_ready=1, out_valid={0,0}.
- Enqueue pair pc=0x100/0x104 with no accept -> next cycle count=2, out_entry[0].pc=0x100, out_entry[1].pc=0x104, out_valid={1,1}.
- Compaction: in_entry[0] invalid, in_entry[1] valid with pc=0x200, into an empty queue -> count=1, out_entry[0].pc=0x200, out_valid={1,0}.
- Fill to count=7 (DEPTH=8) -> in_ready=0; a held pair is not written. Then accept={1,1} -> count=5, in_ready=1, and the held pair enqueues the next cycle.
- Wrap: make tail=7 and head=6 via enqueue/dequeue sequences, then enqueue pc=0x300/0x304 while accept={1,0} -> count +1 net; 0x300 is stored at index 7 and 0x304 at index 0; drain order is preserved.
- Flush with count=4 together with a valid enqueue and accept={1,1} -> next cycle count=0, out_valid={0,0}, no entry from the flush cycle survives.
- Illegal accept: accept={0,1} with count=2 -> count stays 2 and head is unchanged.
